// File: rtl/smps_pkg.sv
// smps_pkg: state encoding and shared defaults for the SMPS control stages
package smps_pkg;
    typedef enum logic [1:0] {IDLE, RAMP_UP, TRACK, RAMP_DOWN} state_t;
    localparam int DEF_DUTY_W   = 8;
    localparam int CLK_HZ       = 200_000_000;
    localparam int STEP_HZ      = 10_000;
    localparam int DEF_STEP_DIV = CLK_HZ / STEP_HZ;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchroniser for one asynchronous input bit
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    // second flop gives the first a full cycle to settle out of metastability
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, meta} <= 2'b00;
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/duty_soft_start.sv
// duty_soft_start: ramps the PWM duty command toward a clamped target; define SOFT_STOP_EN to ramp down on disable
module duty_soft_start
    import smps_pkg::*;
#(
    parameter int DUTY_W    = DEF_DUTY_W,
    parameter int STEP_DIV  = DEF_STEP_DIV,
    parameter int STEP_SIZE = 1,
    parameter int MAX_DUTY  = 242
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DUTY_W-1:0] i_target_duty,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_ramping,
    output logic              o_at_target
);
    localparam int CNT_W = 24;
    localparam logic [DUTY_W-1:0] MAX_D = DUTY_W'(MAX_DUTY);
    localparam logic [DUTY_W-1:0] STEP  = DUTY_W'(STEP_SIZE);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(STEP_DIV - 1);

    state_t            state;
    logic              en_s, tick;
    logic [CNT_W-1:0]  cnt;
    logic [DUTY_W-1:0] tgt_r, tgt, up;
    logic [DUTY_W:0]   sum;
`ifdef SOFT_STOP_EN
    logic [DUTY_W-1:0] dn;
`endif

    sync_2ff u_sync (.clk(clk), .rst(rst), .d(enable), .q(en_s));

    // target sampled every cycle; a decrease reaches o_duty on the following edge
    always_ff @(posedge clk or posedge rst)
        if (rst) tgt_r <= '0;
        else tgt_r <= i_target_duty;

    // clamped target, saturating step values (sum carries an extra bit so it cannot wrap) and prescaler tick
    always_comb begin
        tgt  = tgt_r > MAX_D ? MAX_D : tgt_r;
        sum  = {1'b0, o_duty} + {1'b0, STEP};
        up   = sum > {1'b0, tgt} ? tgt : sum[DUTY_W-1:0];
`ifdef SOFT_STOP_EN
        dn   = o_duty > STEP ? o_duty - STEP : '0;
`endif
        tick = cnt == LAST;
    end

    // ramp FSM with registered duty and flags; every state change restarts the prescaler
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            o_duty      <= '0;
            o_ramping   <= 1'b0;
            o_at_target <= 1'b0;
            cnt         <= '0;
        end else if (!en_s && (state == RAMP_UP || state == TRACK)) begin
`ifdef SOFT_STOP_EN
            state       <= RAMP_DOWN;
            o_ramping   <= 1'b1;
`else
            state       <= IDLE;
            o_duty      <= '0;
            o_ramping   <= 1'b0;
`endif
            o_at_target <= 1'b0;
            cnt         <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            case (state)
                IDLE:
                    if (en_s && tgt != '0) begin
                        state     <= RAMP_UP;
                        o_ramping <= 1'b1;
                        cnt       <= '0;
                    end
                RAMP_UP:
                    if (tgt < o_duty || (tick && up == tgt)) begin
                        state       <= TRACK;
                        o_duty      <= tgt;
                        o_ramping   <= 1'b0;
                        o_at_target <= 1'b1;
                        cnt         <= '0;
                    end else if (tick) o_duty <= up;
                TRACK:
                    if (tgt > o_duty) begin
                        state       <= RAMP_UP;
                        o_ramping   <= 1'b1;
                        o_at_target <= 1'b0;
                        cnt         <= '0;
                    end else o_duty <= tgt;
`ifdef SOFT_STOP_EN
                RAMP_DOWN:
                    if (en_s) begin
                        state <= RAMP_UP;
                        cnt   <= '0;
                    end else if (tick) begin
                        o_duty <= dn;
                        if (dn == '0) begin
                            state     <= IDLE;
                            o_ramping <= 1'b0;
                            cnt       <= '0;
                        end
                    end
`endif
                default: begin
                    state       <= IDLE;
                    o_duty      <= '0;
                    o_ramping   <= 1'b0;
                    o_at_target <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_duty_soft_start.sv
// tb_duty_soft_start: scoreboard bench for duty_soft_start with directed and randomized target/enable activity
`timescale 1ns/1ps
module tb_duty_soft_start;
    localparam int DIV = 4, STEP = 16, MAXD = 242;
    typedef struct { int duty; bit at; bit rmp; int gap; int due; } exp_t;

    logic       clk = 0, rst = 1, enable = 0;
    logic [7:0] target = 0, o_duty;
    logic       o_ramping, o_at_target;
    exp_t       q[$];
    int         vectors = 0, miscompares = 0, cyc = 0, cur = 0, tgt = 0;
    bit         en = 0;

    duty_soft_start #(.DUTY_W(8), .STEP_DIV(DIV), .STEP_SIZE(STEP), .MAX_DUTY(MAXD)) dut (
        .clk(clk), .rst(rst), .enable(enable), .i_target_duty(target),
        .o_duty(o_duty), .o_ramping(o_ramping), .o_at_target(o_at_target));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clamp(int t);
        return t > MAXD ? MAXD : t;
    endfunction

    function automatic void push(int d, bit at, bit rmp, int gap, int due);
        exp_t e;
        e.duty = d; e.at = at; e.rmp = rmp; e.gap = gap; e.due = due;
        q.push_back(e);
    endfunction

    // every intermediate value is min(prev+STEP, to); only the last one is "at target"
    function automatic void push_ramp(int from, int to, int due);
        int v = from;
        bit first = 1;
        while (v < to) begin
            v = v + STEP > to ? to : v + STEP;
            push(v, v == to, v != to, first ? 0 : DIV, first ? due : 0);
            first = 0;
        end
    endfunction

    function automatic void push_off(int from, int now);
`ifdef SOFT_STOP_EN
        int v = from;
        bit first = 1;
        while (v > 0) begin
            v = v > STEP ? v - STEP : 0;
            push(v, 0, v != 0, first ? 0 : DIV, first ? now + 7 : 0);
            first = 0;
        end
`else
        if (from != 0) push(0, 0, 0, 0, now + 3);
`endif
    endfunction

    task automatic set_target(int t);
        int tc;
        @(negedge clk);
        target = t[7:0];
        tc = clamp(t);
        if (en && tc < cur) push(tc, 1, 0, 0, cyc + 2);
        else if (en && tc > cur) push_ramp(cur, tc, cyc + 6);
        if (en) cur = tc;
        tgt = tc;
    endtask

    task automatic set_enable(bit v);
        @(negedge clk);
        enable = v;
        if (v && !en && tgt > 0) begin
            push_ramp(0, tgt, cyc + 7);
            cur = tgt;
        end
        if (!v && en) begin
            push_off(cur, cyc);
            cur = 0;
        end
        en = v;
    endtask

    task automatic wait_left(int n);
        int k = 0;
        while (q.size() > n && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("wait for ramp progress", q.size(), n);
    endtask

    task automatic drain();
        wait_left(0);
        q.delete();
    endtask

    // monitor: every o_duty change must match the next expected step
    initial begin
        int last = 0;
        exp_t e;
        @(negedge rst);
        forever begin
            @(o_duty);
            #1;
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected duty change: got %0d with nothing expected", o_duty);
            end else begin
                e = q.pop_front();
                if (o_duty != e.duty || o_at_target != e.at || o_ramping != e.rmp ||
                    (e.gap != 0 && cyc - last != e.gap) || (e.due != 0 && cyc != e.due)) begin
                    miscompares++;
                    $display("FAIL duty step: got duty=%0d at=%0b ramp=%0b gap=%0d cyc=%0d, expected duty=%0d at=%0b ramp=%0b gap=%0d cyc=%0d",
                             o_duty, o_at_target, o_ramping, cyc - last, cyc, e.duty, e.at, e.rmp, e.gap, e.due);
                end
            end
            last = cyc;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset o_duty", o_duty, 0);
        chk("reset o_ramping", o_ramping, 0);
        chk("reset o_at_target", o_at_target, 0);
        rst = 0;
        set_target(64);
        repeat (4) @(negedge clk);
        set_enable(1);
        repeat (2) @(posedge clk);
        #1 chk("ramping before sync", o_ramping, 0);
        @(posedge clk);
        #1 chk("ramping after sync", o_ramping, 1);
        drain();
        chk("at_target after ramp", o_at_target, 1);
        set_target(255);
        drain();
        chk("clamped duty", o_duty, 242);
        set_enable(0);
        repeat (2) @(posedge clk);
        #1 chk("duty before enable_s falls", o_duty, 242);
        @(posedge clk);
`ifdef SOFT_STOP_EN
        #1 chk("ramp down entered", o_ramping, 1);
`else
        #1 chk("duty one edge after enable_s falls", o_duty, 0);
`endif
        drain();
        repeat (12) @(negedge clk);
        set_target(64);
        set_enable(1);
        wait_left(1);
        chk("duty before decrease", o_duty, 48);
        q.delete();
        cur = 48;
        set_target(20);
        drain();
        chk("decrease lands in track", o_at_target, 1);
        chk("decreased duty", o_duty, 20);
        set_target(64);
        drain();
        set_target(100);
        drain();
        chk("increase back at target", o_at_target, 1);
        chk("increased duty", o_duty, 100);
        set_enable(0);
        drain();
        repeat (12) @(negedge clk);
        set_target(64);
        set_enable(1);
        wait_left(2);
        q.delete();
        #2;
        push(0, 0, 0, 0, 0);
        rst = 1;
        #1 chk("async reset duty", o_duty, 0);
        chk("async reset ramping", o_ramping, 0);
        @(negedge clk);
        rst = 0;
        push_ramp(0, 64, cyc + 7);
        cur = 64;
        drain();
        chk("ramp restarted after reset", o_duty, 64);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            int r = $urandom_range(0, 4);
            if (r == 0) set_target($urandom_range(0, 1) ? 255 : 0);
            else if (r < 3) set_target($urandom_range(0, 255));
            else set_enable(!en);
            drain();
            repeat (12) @(negedge clk);
            chk("random settled duty", o_duty, cur);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/duty_soft_start.md
# duty_soft_start

Soft-start duty ramp generator feeding the open-loop, no-soft-start PWM stage. It replaces the direct switch-to-duty connection (SW[17:10] into the PWM's duty input) with a registered duty command. When enabled, that command ramps from 0 up to the requested target in fixed steps at a programmable rate, which limits inrush current at converter start-up. It runs on the 200 MHz PLL clock, and its o_duty drives the PWM stage's i_sw_duty.

## Interface
- DUTY_W, 8, width of duty words (matches PWM duty input)
- STEP_DIV, 20000, clk cycles per ramp step (100 us at 200 MHz); legal range 2..2^24-1
- STEP_SIZE, 1, duty LSBs added or removed per step; legal range 1..2^DUTY_W-1
- MAX_DUTY, 242, clamp applied to target (about 95 %)
- clk  in  1  200 MHz system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run request, asynchronous to clk (switch)
- i_target_duty  in  DUTY_W  requested duty, quasi-static
- o_duty  out  DUTY_W  registered duty command to PWM stage
- o_ramping  out  1  high while duty is moving toward its goal
- o_at_target  out  1  high while in TRACK

## Operation
- Input conditioning:
  - enable passes through a 2-flop synchroniser.
  - i_target_duty is registered every cycle, then clamped: tgt = min(i_target_duty, MAX_DUTY).
- Prescaler:
  - Counts 0..STEP_DIV-1; tick = (count == STEP_DIV-1).
  - Clears on any state change, so the first step lands exactly STEP_DIV cycles after the state is entered.
- FSM states:
  - IDLE: duty = 0.
    - If enable_s and tgt > 0, go to RAMP_UP.
    - If enable_s and tgt == 0, stay in IDLE.
  - RAMP_UP: on each tick, duty = min(duty + STEP_SIZE, tgt), computed at DUTY_W+1 bits with no wrap.
    - When the new duty equals tgt, go to TRACK.
    - If tgt falls below duty, duty = tgt immediately (decrease is the safe direction), then go to TRACK.
  - TRACK: duty follows any tgt decrease in the same cycle.
    - A tgt increase returns the FSM to RAMP_UP; increases are always ramped.
  - Any state except IDLE, when enable_s drops: behaviour depends on SOFT_STOP_EN (see Configuration).
- Outputs:
  - o_ramping = state is RAMP_UP or RAMP_DOWN.
  - o_at_target = state is TRACK.
- Reset values: o_duty = 0, o_ramping = 0, o_at_target = 0, state IDLE, prescaler 0, synchroniser flops 0.
- Reset asserted mid-ramp forces duty to 0 immediately (asynchronous); there is no ramp-down on reset.

## Timing
- enable rising at edge N: state is RAMP_UP after edge N+3 (2 synchroniser edges plus 1 FSM edge).
- First duty increment appears STEP_DIV cycles after RAMP_UP is entered.
- Full ramp takes ceil(tgt/STEP_SIZE) × STEP_DIV cycles.
- Target decrease: o_duty updates 2 cycles after the i_target_duty change (input register, then output register).
- Simultaneous tick and target decrease: the decrease wins, so duty = tgt with no increment.
- Simultaneous tick and enable drop: the enable drop wins.
- o_duty changes only on a clk edge and is glitch-free into the PWM stage.

## Configuration
- SOFT_STOP_EN defined:
  - Enable drop enters RAMP_DOWN.
  - Each tick sets duty = max(duty - STEP_SIZE, 0); the subtraction saturates.
  - Reaching duty = 0 returns the FSM to IDLE.
  - enable_s re-asserting during RAMP_DOWN goes straight to RAMP_UP from the current duty.
- SOFT_STOP_EN undefined:
  - Enable drop forces duty = 0 and returns to IDLE in one edge.
  - The RAMP_DOWN state is not built.

## Structure
- Shared package smps_pkg holds:
  - the state enumeration (IDLE, RAMP_UP, TRACK, RAMP_DOWN)
  - DUTY_W default
  - the default clock frequency constant used to derive STEP_DIV
- One sub-module, sync_2ff, the generic 2-flop bit synchroniser, reused by later stages for the switch and key inputs.
- The prescaler and FSM stay inline.

## Test plan
All scenarios use STEP_DIV=4, STEP_SIZE=16, MAX_DUTY=242.
- Ramp up: rst, then enable=1 with target=64 → o_duty goes 0, 16, 32, 48, 64 at 4-cycle spacing; o_at_target rises with 64; o_ramping is high only in between.
- Clamp and no overshoot: target=255 → ramp ends at exactly 242, never 256 or a wrapped value.
- Decrease during ramp: at duty=48, target drops to 20 → o_duty=20 two cycles later and the FSM is in TRACK.
- Increase in TRACK: from TRACK at 64, target set to 100 → steps 80, 96, 100, then o_at_target re-asserts.
- Disable:
  - SOFT_STOP_EN defined, from 64: duty goes 48, 32, 16, 0, then IDLE.
  - SOFT_STOP_EN undefined: o_duty=0 one edge after enable_s falls.
- Mid-ramp reset: rst pulsed at duty=32 → o_duty=0 asynchronously; after release with enable still 1, the ramp restarts from 0.
